// File: rtl/max7219_pkg.sv
// Shared constants and types for the MAX7219 display driver.
// The optional PM_DOT_EN build macro is consumed in max7219_display_driver.sv.
package max7219_pkg;

  localparam int FRAME_W           = 16;
  localparam int LAST_FRAME        = 10;
  localparam int FIRST_DIGIT_FRAME = 5;

  localparam logic [3:0] REG_DIGIT0    = 4'h1;
  localparam logic [3:0] REG_DIGIT1    = 4'h2;
  localparam logic [3:0] REG_DIGIT2    = 4'h3;
  localparam logic [3:0] REG_DIGIT3    = 4'h4;
  localparam logic [3:0] REG_DIGIT4    = 4'h5;
  localparam logic [3:0] REG_DIGIT5    = 4'h6;
  localparam logic [3:0] REG_DECODE    = 4'h9;
  localparam logic [3:0] REG_INTENSITY = 4'hA;
  localparam logic [3:0] REG_SCAN      = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
  localparam logic [3:0] REG_TEST      = 4'hF;

  localparam logic [7:0] SHUTDOWN_OFF  = 8'h01;
  localparam logic [7:0] TEST_OFF      = 8'h00;
  localparam logic [7:0] DECODE_B_D0_5 = 8'h3F;
  localparam logic [7:0] SCAN_D0_5     = 8'h05;

  typedef logic [1:0] tx_state_t;
  localparam tx_state_t ST_IDLE  = 2'd0;
  localparam tx_state_t ST_LOAD  = 2'd1;
  localparam tx_state_t ST_SHIFT = 2'd2;
  localparam tx_state_t ST_GAP   = 2'd3;

  typedef struct packed {
    logic [3:0] hours_msd;
    logic [3:0] hours_lsd;
    logic [3:0] minutes_msd;
    logic [3:0] minutes_lsd;
    logic [3:0] seconds_msd;
    logic [3:0] seconds_lsd;
  } time_snap_t;

  function automatic logic [FRAME_W-1:0] make_frame(input logic [3:0] addr, input logic [7:0] data);
    return {4'h0, addr, data};
  endfunction

  function automatic logic [FRAME_W-1:0] digit_frame(input logic [3:0] addr, input logic dp,
                                                     input logic [3:0] digit);
    return {4'h0, addr, dp, 3'b000, digit};
  endfunction

endpackage

// File: rtl/max7219_display_driver_spi_frame_tx.sv
// Single 16-bit frame transmitter for the MAX7219 3-wire link.
// Owns sclk/mosi/cs_n timing; a start seen in IDLE or on the last GAP cycle launches a frame.
//
// state | meaning
// IDLE  | link idle, cs_n high, waiting for start
// LOAD  | one cycle: cs_n low, mosi shows bit 15, shifter loaded
// SHIFT | 16 bits, each CLK_DIV cycles sclk low then CLK_DIV cycles sclk high
// GAP   | cs_n high for CLK_DIV cycles, rising cs_n latches the frame
module spi_frame_tx
  import max7219_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [FRAME_W-1:0] data,
  output logic               done,
  output logic               sclk,
  output logic               mosi,
  output logic               cs_n
);

  localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

  tx_state_t          state;
  logic [DIV_W-1:0]   div_cnt;
  logic [3:0]         bit_cnt;
  logic               phase_high;
  logic [FRAME_W-1:0] shreg;
  logic               div_tc;

  assign div_tc = (div_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      div_cnt    <= '0;
      bit_cnt    <= 4'd0;
      phase_high <= 1'b0;
      shreg      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) state <= ST_LOAD;
        end
        ST_LOAD: begin
          shreg      <= data;
          bit_cnt    <= 4'd15;
          div_cnt    <= DIV_LOAD;
          phase_high <= 1'b0;
          state      <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (!div_tc) begin
            div_cnt <= div_cnt - 1'b1;
          end else begin
            div_cnt <= DIV_LOAD;
            if (!phase_high) begin
              phase_high <= 1'b1;
            end else begin
              // end of a high phase: next bit appears with the sclk fall
              phase_high <= 1'b0;
              if (bit_cnt == 4'd0) begin
                state <= ST_GAP;
              end else begin
                bit_cnt <= bit_cnt - 4'd1;
                shreg   <= {shreg[FRAME_W-2:0], 1'b0};
              end
            end
          end
        end
        ST_GAP: begin
          if (!div_tc) div_cnt <= div_cnt - 1'b1;
          else         state   <= start ? ST_LOAD : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode straight from state so an async reset clears the pins at once.
  assign done = (state == ST_GAP) && div_tc;
  assign cs_n = !((state == ST_LOAD) || (state == ST_SHIFT));
  assign sclk = (state == ST_SHIFT) && phase_high;

  always_comb begin
    mosi = 1'b0;
    if (state == ST_LOAD)       mosi = data[FRAME_W-1];
    else if (state == ST_SHIFT) mosi = shreg[FRAME_W-1];
  end

endmodule

// File: rtl/max7219_display_driver.sv
// Snapshots the BCD time on refresh and streams config + digit frames to a MAX7219.
// Build macro PM_DOT_EN: light the decimal point of the hours_lsd digit when pm is set.
module max7219_display_driver
  import max7219_pkg::*;
#(
  parameter int         CLK_DIV   = 2,
  parameter logic [3:0] INTENSITY = 4'h8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh,
  input  logic       pm,
  input  logic [3:0] hours_msd,
  input  logic [3:0] hours_lsd,
  input  logic [3:0] minutes_msd,
  input  logic [3:0] minutes_lsd,
  input  logic [3:0] seconds_msd,
  input  logic [3:0] seconds_lsd,
  output logic       busy,
  output logic       sclk,
  output logic       mosi,
  output logic       cs_n
);

  time_snap_t         snap;
  logic [3:0]         idx;
  logic               init_pending;
  logic               accept;
  logic               last;
  logic               tx_start;
  logic               tx_done;
  logic               dp_hours;
  logic [FRAME_W-1:0] frame;

  assign accept   = refresh && !busy;
  assign last     = (idx == 4'(LAST_FRAME));
  assign tx_start = accept || (tx_done && !last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy         <= 1'b0;
      init_pending <= 1'b1;
      idx          <= 4'd0;
      snap         <= '0;
    end else if (accept) begin
      busy             <= 1'b1;
      idx              <= init_pending ? 4'd0 : 4'(FIRST_DIGIT_FRAME);
      snap.hours_msd   <= hours_msd;
      snap.hours_lsd   <= hours_lsd;
      snap.minutes_msd <= minutes_msd;
      snap.minutes_lsd <= minutes_lsd;
      snap.seconds_msd <= seconds_msd;
      snap.seconds_lsd <= seconds_lsd;
    end else if (tx_done) begin
      if (last) begin
        busy         <= 1'b0;
        init_pending <= 1'b0;
      end else begin
        idx <= idx + 4'd1;
      end
    end
  end

`ifdef PM_DOT_EN
  logic snap_pm;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       snap_pm <= 1'b0;
    else if (accept) snap_pm <= pm;
  end

  assign dp_hours = snap_pm;
`else
  logic unused_pm;

  assign unused_pm = pm;
  assign dp_hours  = 1'b0;
`endif

  always_comb begin
    frame = '0;
    case (idx)
      4'd0:  frame = make_frame(REG_SHUTDOWN, SHUTDOWN_OFF);
      4'd1:  frame = make_frame(REG_TEST, TEST_OFF);
      4'd2:  frame = make_frame(REG_DECODE, DECODE_B_D0_5);
      4'd3:  frame = make_frame(REG_SCAN, SCAN_D0_5);
      4'd4:  frame = make_frame(REG_INTENSITY, {4'h0, INTENSITY});
      4'd5:  frame = digit_frame(REG_DIGIT0, 1'b0, snap.seconds_lsd);
      4'd6:  frame = digit_frame(REG_DIGIT1, 1'b0, snap.seconds_msd);
      4'd7:  frame = digit_frame(REG_DIGIT2, 1'b0, snap.minutes_lsd);
      4'd8:  frame = digit_frame(REG_DIGIT3, 1'b0, snap.minutes_msd);
      4'd9:  frame = digit_frame(REG_DIGIT4, dp_hours, snap.hours_lsd);
      4'd10: frame = digit_frame(REG_DIGIT5, 1'b0, snap.hours_msd);
      default: frame = '0;
    endcase
  end

  spi_frame_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .clk   (clk),
    .rst   (reset),
    .start (tx_start),
    .data  (frame),
    .done  (tx_done),
    .sclk  (sclk),
    .mosi  (mosi),
    .cs_n  (cs_n)
  );

endmodule

// File: doc/max7219_display_driver.md
Name: max7219_display_driver

Overview:
- Reader/consumer side of the BCD time register: snapshots the six BCD digits plus the pm flag and streams them to a MAX7219 7-segment driver over a write-only 3-wire serial link (sclk, mosi, cs_n).
- Sits between the clock core and the chip pins.
- Sends a one-time configuration sequence after reset, then digit frames on every refresh strobe.

Parameters:
- CLK_DIV, 2, clk cycles per sclk half-period (≥1).
- INTENSITY, 4'h8, value for the MAX7219 intensity register.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous reset, active-high
- refresh  input  1  single-cycle request to send the current time
- pm  input  1  PM flag from the time register
- hours_msd  input  4  BCD digit
- hours_lsd  input  4  BCD digit
- minutes_msd  input  4  BCD digit
- minutes_lsd  input  4  BCD digit
- seconds_msd  input  4  BCD digit
- seconds_lsd  input  4  BCD digit
- busy  output  1  transfer sequence in progress
- sclk  output  1  serial clock (idle low)
- mosi  output  1  serial data, MSB first
- cs_n  output  1  frame select/latch (idle high)

Behaviour:
- Reset: busy=0, sclk=0, mosi=0, cs_n=1, FSM=IDLE, init_pending=1, snapshot registers=0.
- Reset mid-frame aborts immediately, with no partial latch beyond what cs_n rising causes; the config sequence is resent on the next refresh.
- Frame format: 16 bits {4'h0, addr[3:0], data[7:0]}, MSB first.
- FSM states: IDLE -> LOAD -> SHIFT -> GAP -> (LOAD | IDLE).
- IDLE:
  - refresh=1 captures all six digits and pm into the snapshot at that edge.
  - Sets frame index to 0 if init_pending, else 5.
  - Goes to LOAD.
  - refresh while busy is ignored; there is no queuing.
- LOAD (1 cycle):
  - Selects the frame word by index, loads the shifter and bit counter 15.
  - Asserts cs_n=0 and drives mosi=bit15; sclk stays 0.
- SHIFT: each bit occupies 2*CLK_DIV cycles, CLK_DIV with sclk=0 then CLK_DIV with sclk=1.
  - mosi updates only at the sclk falling transition, i.e. the start of a low phase.
  - After the high phase of bit 0, sclk returns to 0 and the FSM goes to GAP.
- GAP: cs_n=1 for CLK_DIV cycles; the cs_n rising edge latches the frame.
  - If the index is 10, go to IDLE and clear init_pending.
  - Otherwise increment the index and go to LOAD.
- busy=1 from the cycle after the accepted refresh through the last GAP cycle; busy=0 in IDLE.
- Frame table, index: addr, data:
  - 0: 0xC, 0x01 (shutdown off)
  - 1: 0xF, 0x00 (test off)
  - 2: 0x9, 0x3F (code-B on digits 0-5)
  - 3: 0xB, 0x05 (scan limit 6)
  - 4: 0xA, {4'h0, INTENSITY}
  - 5..10: addr 1..6, data {dp, 3'b000, digit}
- Digit order for addr 1..6: seconds_lsd, seconds_msd, minutes_lsd, minutes_msd, hours_lsd, hours_msd.
- dp=0 unless the optional feature sets it.
- Digit values >9 are passed through unchanged (code-B 0xA='-', 0xF=blank).
- Frame duration: 1 + 32*CLK_DIV + CLK_DIV cycles.
- The snapshot is stable for the whole sequence; input changes mid-sequence do not affect sent data.

Optional Feature:
- Macro: PM_DOT_EN.
- Defined: the addr-5 (hours_lsd) frame sets dp=snapshot pm.
- Undefined: dp=0 on all frames and the pm input is unused.

Decomposition:
- Package max7219_pkg holds:
  - register address constants (REG_DIGIT0..5, REG_DECODE, REG_INTENSITY, REG_SCAN, REG_SHUTDOWN, REG_TEST)
  - config data constants
  - the FSM state enum
  - FRAME_W=16 and LAST_FRAME=10
- One sub-module, spi_frame_tx: a 16-bit shifter plus CLK_DIV divider with start/done handshake. It owns sclk, mosi, cs_n and the LOAD/SHIFT/GAP timing; the parent owns the frame index, snapshot and init_pending.

Test Plan:
- Reset, then refresh with time 12:34:56, pm=1, CLK_DIV=2:
  - busy rises next cycle.
  - 11 frames decoded: 0x0C01, 0x0F00, 0x093F, 0x0B05, 0x0A08, 0x0106, 0x0205, 0x0304, 0x0403, 0x0502 (0x0582 with PM_DOT_EN), 0x0601.
  - busy is high 11*67=737 cycles.
- Second refresh with 12:34:57: only 6 digit frames, first is 0x0107, busy for 402 cycles; no config frames.
- Pulse refresh during busy, and change seconds_lsd mid-sequence: no extra frames, and the sent data equals the snapshot taken at acceptance.
- Assert reset during bit 7 of frame 3: the same cycle gives cs_n=1, sclk=0, mosi=0, busy=0. The next refresh resends all 11 frames.
- Timing check CLK_DIV=3:
  - sclk low/high phases are exactly 3 cycles.
  - mosi is stable throughout every high phase.
  - cs_n is high for 3 cycles between frames.
- Digit value 4'hF on hours_msd: frame 0x060F is sent unmodified.
